// File: rtl/spd_pkg.sv
// spd_pkg: shared constants for the SM2 multiply/reduce datapath.
//   - SM2 curve parameters (P256 is the SM2 field prime)
//   - default B-operand limb width for the iterative multiplier
//   - 2-bit state encodings and the matching enum type
//   - operand width constants W256 / W512
package spd_pkg;

    localparam int W256       = 256;
    localparam int W512       = 512;
    localparam int LIMB_W_DEF = 64;

    localparam logic [W256-1:0] SM2_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [W256-1:0] SM2_A =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFC;
    localparam logic [W256-1:0] SM2_B =
        256'h28E9FA9E_9D9F5E34_4D5A9E4B_CF6509A7_F39789F5_15AB8F92_DDBCBD41_4D940E93;
    localparam logic [W256-1:0] SM2_N =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_7203DF6B_21C6052B_53BBF409_39D54123;
    localparam logic [W256-1:0] P256 = SM2_P;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_MUL  = MUL,
        S_DONE = DONE
    } spd_mul_state_t;

endpackage

// File: rtl/spd_mul_row.sv
// spd_mul_row: combinational 256 x LIMB_W unsigned row multiplier.
// Kept as its own module so it can be mapped onto DSP blocks or have
// pipeline stages added without touching the control logic.
// Ports:
//   i_a      [255:0]          multiplicand (full width)
//   i_b_limb [LIMB_W-1:0]     one limb of the multiplier
//   o_row    [256+LIMB_W-1:0] full-width unsigned product
module spd_mul_row
    import spd_pkg::*;
#(
    parameter int LIMB_W = LIMB_W_DEF
) (
    input  logic [W256-1:0]        i_a,
    input  logic [LIMB_W-1:0]      i_b_limb,
    output logic [W256+LIMB_W-1:0] o_row
);

    localparam int ROW_W = W256 + LIMB_W;

    assign o_row = ROW_W'(i_a) * ROW_W'(i_b_limb);

endmodule

// File: rtl/spd_mul_256.sv
// spd_mul_256: iterative 256x256 unsigned multiplier feeding the SM2 fast
// reducer. One B limb is consumed per cycle; the 512-bit product is
// registered and announced by a one-cycle mul_fin_o pulse.
//
// Optional feature macro: SPD_MUL_SQR_EN (adds sqr_i; when set at accept,
// the multiplier operand is taken from p256_a so the result is a*a).
//
// Ports:
//   clk        system clock
//   rst_n      synchronous reset, active-high despite the name
//   sqr_i      square select, sampled at accept (SPD_MUL_SQR_EN only)
//   mul_vld_i  operand valid, accepted when mul_rdy_o is high
//   mul_rdy_o  ready to accept operands (IDLE or DONE)
//   p256_a     multiplicand
//   p256_b     multiplier
//   p512_p     registered product, holds until the next completion
//   mul_fin_o  one-cycle pulse marking a new p512_p
//
// state | meaning
// IDLE  | waiting for operands, ready high
// MUL   | accumulating one limb row per cycle, ready low
// DONE  | product valid pulse, ready high (back-to-back accept allowed)
module spd_mul_256
    import spd_pkg::*;
#(
    parameter int LIMB_W = LIMB_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef SPD_MUL_SQR_EN
    input  logic            sqr_i,
`endif
    input  logic            mul_vld_i,
    output logic            mul_rdy_o,
    input  logic [W256-1:0] p256_a,
    input  logic [W256-1:0] p256_b,
    output logic [W512-1:0] p512_p,
    output logic            mul_fin_o
);

    localparam int NUM_LIMBS = W256 / LIMB_W;
    localparam int CNT_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

    if ((W256 % LIMB_W) != 0) begin : g_bad_limb
        $error("LIMB_W must divide 256");
    end

    spd_mul_state_t r_state;
    spd_mul_state_t w_state_nxt;

    logic [CNT_W-1:0]         r_cnt;
    logic [W512-1:0]          r_acc;
    logic [W512-1:0]          r_prod;
    logic [W256-1:0]          r_a;
    logic [W256-1:0]          r_b;

    logic [LIMB_W-1:0]        w_limb;
    logic [W256+LIMB_W-1:0]   w_row;
    logic [W512-1:0]          w_term;
    logic [W512-1:0]          w_sum;
    logic                     w_last;
    logic                     w_accept;
    logic [W256-1:0]          w_b_src;

`ifdef SPD_MUL_SQR_EN
    assign w_b_src = sqr_i ? p256_a : p256_b;
`else
    assign w_b_src = p256_b;
`endif

    assign w_limb = r_b[int'(r_cnt)*LIMB_W +: LIMB_W];

    spd_mul_row #(.LIMB_W(LIMB_W)) u_row (
        .i_a      (r_a),
        .i_b_limb (w_limb),
        .o_row    (w_row)
    );

    // Row product is zero-extended to 512 bits before being weighted by the
    // limb position; the total never exceeds 2^512 so no carry-out exists.
    assign w_term   = W512'(w_row) << (int'(r_cnt) * LIMB_W);
    assign w_sum    = r_acc + w_term;
    assign w_last   = (r_cnt == CNT_W'(NUM_LIMBS - 1));
    assign w_accept = mul_rdy_o && mul_vld_i;
    assign p512_p   = r_prod;

    always_comb begin
        w_state_nxt = r_state;
        mul_rdy_o   = 1'b0;
        mul_fin_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                mul_rdy_o = 1'b1;
                if (mul_vld_i) w_state_nxt = S_MUL;
            end
            S_MUL: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                mul_rdy_o   = 1'b1;
                mul_fin_o   = 1'b1;
                w_state_nxt = mul_vld_i ? S_MUL : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_prod  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a   <= p256_a;
                r_b   <= w_b_src;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == S_MUL) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) r_prod <= w_sum;
            end
        end
    end

endmodule

// File: tb/tb_spd_mul_256.sv
module tb_spd_mul_256;
    import spd_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mul_vld_i;
    logic            mul_rdy_o;
    logic [255:0]    p256_a;
    logic [255:0]    p256_b;
    logic [511:0]    p512_p;
    logic            mul_fin_o;
`ifdef SPD_MUL_SQR_EN
    logic            sqr_i = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    spd_mul_256 dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SPD_MUL_SQR_EN
        .sqr_i     (sqr_i),
`endif
        .mul_vld_i (mul_vld_i),
        .mul_rdy_o (mul_rdy_o),
        .p256_a    (p256_a),
        .p256_b    (p256_b),
        .p512_p    (p512_p),
        .mul_fin_o (mul_fin_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Accept one operand pair from IDLE, scramble the inputs afterwards,
    // then check latency, product and the return to IDLE.
    task automatic run_op(input string tag, input logic [255:0] a, input logic [255:0] b,
                          input logic [511:0] exp);
        int cyc;
        chk({tag, "_rdy"}, 512'(mul_rdy_o), 512'd1);
        mul_vld_i = 1'b1;
        p256_a    = a;
        p256_b    = b;
        step();
        mul_vld_i = 1'b0;
        p256_a    = rnd256();
        p256_b    = rnd256();
        cyc = 1;
        while (!mul_fin_o && cyc < 12) begin
            step();
            cyc++;
        end
        chk({tag, "_lat"}, 512'(cyc), 512'd5);
        chk({tag, "_prod"}, p512_p, exp);
        step();
        chk({tag, "_fin_low"}, 512'(mul_fin_o), 512'd0);
        chk({tag, "_hold"}, p512_p, exp);
    endtask

    logic [255:0] all1;
    logic [511:0] e_max, e_2p, e_pow510, e_cross, held;
    logic [255:0] ba [3];
    logic [255:0] bb [3];
    logic [511:0] be [3];
    int cyc, pulses;

    initial begin
        all1     = '1;
        e_max    = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
        e_2p     = 512'h1_FFFFFFFD_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_00000001_FFFFFFFF_FFFFFFFE;
        e_pow510 = 512'd1 << 510;
        e_cross  = 512'h1_0000000000000002_0000000000000001;

        rst_n     = 1'b1;
        mul_vld_i = 1'b0;
        p256_a    = '0;
        p256_b    = '0;
        step();
        step();
        rst_n = 1'b0;
        chk("rst_rdy", 512'(mul_rdy_o), 512'd1);
        chk("rst_fin", 512'(mul_fin_o), 512'd0);
        chk("rst_prod", p512_p, 512'd0);

        run_op("one", 256'd1, 256'd1, 512'd1);
        run_op("max", all1, all1, e_max);
        run_op("p2", P256, 256'd2, e_2p);
        run_op("pow255", 256'd1 << 255, 256'd1 << 255, e_pow510);
        run_op("cross", 256'h1_0000000000000001, 256'h1_0000000000000001, e_cross);

        for (int i = 0; i < 16; i++) begin
            logic [255:0] ra, rb;
            ra = rnd256();
            rb = rnd256();
            run_op("rand", ra, rb, {256'd0, ra} * {256'd0, rb});
        end

        // Back-to-back with mul_vld_i held high across three operations.
        ba[0] = 256'd3;        bb[0] = 256'd5;        be[0] = 512'd15;
        ba[1] = 256'd1 << 64;  bb[1] = 256'd1 << 192;  be[1] = 512'd1 << 256;
        ba[2] = all1;          bb[2] = 256'd1;        be[2] = {256'd0, all1};
        mul_vld_i = 1'b1;
        p256_a    = ba[0];
        p256_b    = bb[0];
        for (int k = 0; k < 3; k++) begin
            held = p512_p;
            step();
            if (k < 2) begin
                p256_a = ba[k+1];
                p256_b = bb[k+1];
            end else begin
                mul_vld_i = 1'b0;
                p256_a    = rnd256();
                p256_b    = rnd256();
            end
            chk("b2b_busy", 512'(mul_rdy_o), 512'd0);
            cyc = 1;
            while (!mul_fin_o && cyc < 12) begin
                chk("b2b_gap_low", 512'(mul_fin_o), 512'd0);
                chk("b2b_hold", p512_p, held);
                step();
                cyc++;
            end
            chk("b2b_spacing", 512'(cyc), 512'd5);
            chk("b2b_prod", p512_p, be[k]);
            chk("b2b_rdy_done", 512'(mul_rdy_o), 512'd1);
        end
        step();
        chk("b2b_end_fin", 512'(mul_fin_o), 512'd0);
        chk("b2b_end_rdy", 512'(mul_rdy_o), 512'd1);

        // Operands offered during MUL must be ignored.
        mul_vld_i = 1'b1;
        p256_a    = 256'd7;
        p256_b    = 256'd9;
        step();
        p256_a = 256'd1000;
        p256_b = 256'd1000;
        step();
        chk("busy_rdy", 512'(mul_rdy_o), 512'd0);
        step();
        mul_vld_i = 1'b0;
        cyc = 3;
        while (!mul_fin_o && cyc < 12) begin
            step();
            cyc++;
        end
        chk("busy_lat", 512'(cyc), 512'd5);
        chk("busy_prod", p512_p, 512'd63);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (mul_fin_o) pulses++;
        end
        chk("busy_no_queue", 512'(pulses), 512'd0);

        // Reset in the middle of an operation.
        mul_vld_i = 1'b1;
        p256_a    = 256'd11;
        p256_b    = 256'd13;
        step();
        mul_vld_i = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        chk("abort_rdy", 512'(mul_rdy_o), 512'd1);
        chk("abort_prod", p512_p, 512'd0);
        chk("abort_fin", 512'(mul_fin_o), 512'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (mul_fin_o) pulses++;
        end
        chk("abort_no_fin", 512'(pulses), 512'd0);

        // Reset together with valid: nothing accepted.
        run_op("pre_rv", 256'd6, 256'd7, 512'd42);
        rst_n     = 1'b1;
        mul_vld_i = 1'b1;
        p256_a    = 256'd2;
        p256_b    = 256'd2;
        step();
        rst_n     = 1'b0;
        mul_vld_i = 1'b0;
        chk("rstvld_rdy", 512'(mul_rdy_o), 512'd1);
        chk("rstvld_prod", p512_p, 512'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (mul_fin_o) pulses++;
        end
        chk("rstvld_no_fin", 512'(pulses), 512'd0);

`ifdef SPD_MUL_SQR_EN
        sqr_i = 1'b1;
        run_op("sqr", 256'h1234, all1, 512'h14B5A90);
        sqr_i = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
